memory_access_controller: RTL
=============================

# memory_access_controller

Sequences single-word reads and writes to the data memory for the stack-machine datapath. Consumes the 16-bit address chosen by the memory address selector, plus write data and a request from the control unit. Drives a synchronous, wait-stated memory port and returns read data with a one-cycle completion pulse. The control unit stalls on `Busy` and resumes on `Done`.

## Interface
- `ADDR_W`, 16: address width, matching the selector output.
- `DATA_W`, 16: data word width.
- `WAIT_STATES`, 2: extra memory cycles per access, legal range 0..7.
- `MEM_LIMIT`, 16'hFFFF: highest legal word address. Used only with the fault feature.

Ports:
- `CLK`  in  1: single clock; all state changes on its rising edge.
- `Reset_n`  in  1: synchronous, active-low reset.
- `Req`  in  1: access request, sampled only in IDLE.
- `We`  in  1: 1 = write, 0 = read; sampled with `Req`.
- `Addr`  in  ADDR_W: word address from the memory address selector.
- `WData`  in  DATA_W: write data, sampled with `Req`.
- `Busy`  out  1: high in ACCESS and WAIT.
- `Done`  out  1: one-cycle completion pulse.
- `RData`  out  DATA_W: last read result; held until the next read completes.
- `Fault`  out  1: one-cycle pulse for an out-of-range access.
- `MemAddr`  out  ADDR_W: registered memory address.
- `MemWData`  out  DATA_W: registered memory write data.
- `MemEn`  out  1: memory enable.
- `MemWe`  out  1: memory write strobe.
- `MemRData`  in  DATA_W: memory read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - If `Req`=1: latch `Addr` into `MemAddr`, `WData` into `MemWData`, and `We` internally; go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS** (1 cycle)
  - `MemEn`=1.
  - `MemWe` = latched `We`.
  - Load the wait counter with `WAIT_STATES`; go to WAIT.
- **WAIT** (`WAIT_STATES`+1 cycles)
  - `MemEn`=0 and `MemWe`=0; `MemAddr` and `MemWData` held.
  - Counter decrements each cycle. When it reads 0, go to DONE.
  - For a read, capture `MemRData` into `RData` on that same edge.
- **DONE** (1 cycle)
  - `Done`=1; go to IDLE unconditionally. `Req` is ignored in DONE.
- A write never changes `RData`.
- `Addr`, `We` and `WData` changes while `Busy` is high are ignored.
- If `Req` is held high continuously, a new access is accepted in the IDLE cycle that follows each DONE.
- Reset (`Reset_n`=0 at an edge, any state) produces the following on that edge:
  - FSM goes to IDLE; no `Done` is issued for the aborted access.
  - `Busy`, `Done`, `Fault`, `MemEn` and `MemWe` are 0.
  - `MemAddr`, `MemWData` and `RData` are 0.
- A write whose ACCESS cycle has already been sampled by the memory is not rolled back.

## Timing
- All outputs are registered, or decoded only from the state register. No combinational path from `Req` or `Addr` to any output.
- Request sampled at edge 0:
  - ACCESS in cycle 1.
  - WAIT in cycles 2..2+`WAIT_STATES`.
  - `Done` in cycle 3+`WAIT_STATES`.
  - With the default of 2, `Done` is in cycle 5.
- `RData` is valid from the `Done` cycle onward.
- Throughput: one access per `WAIT_STATES`+4 cycles.
- `Busy` and `Done` are never high in the same cycle.

## Configuration
- Macro: `MEMCTL_FAULT_EN`.
- Defined:
  - In IDLE, if `Req`=1 and `Addr` > `MEM_LIMIT`, go directly to DONE.
  - `MemEn` is never asserted for that access, and `RData` is unchanged.
  - `Done` and `Fault` are both 1 in that DONE cycle, which is cycle 1 after the request edge.
- Not defined:
  - No range comparison is made; every address is accessed.
  - `Fault` is tied to 0.

## Structure
- Shared package `memctl_pkg` holds:
  - the state encoding constants (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3);
  - the wait-counter width (3 bits).
- Sub-module `wait_counter`:
  - loadable 3-bit down-counter;
  - inputs: load, enable, load value;
  - output: zero flag, asserted when the count is 0.

## Test plan
- Reset, then read 16'h0040 with `MemRData`=16'hBEEF (`WAIT_STATES`=2) -> `MemEn` high in cycle 1 only, `Done` in cycle 5, `RData`=16'hBEEF.
- Write 16'h1234 to 16'h0010 -> `MemWe`=`MemEn`=1 in cycle 1 with `MemAddr`=16'h0010, `Done` in cycle 5, `RData` unchanged.
- Hold `Req` high for 3 reads -> `Done` in cycles 5, 11 and 17; `Busy` never high together with `Done`.
- Change `Addr` from 16'h0040 to 16'h0099 during WAIT -> `MemAddr` stays 16'h0040.
- Drop `Reset_n` in cycle 2 of a read -> next cycle IDLE, all outputs 0, no `Done`.
- With `MEMCTL_FAULT_EN` and `MEM_LIMIT`=16'h7FFF, read 16'h8000 -> `Fault`=`Done`=1 in cycle 1, `MemEn` never high.

Source files
------------

// File: rtl/memctl_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding
// and the width of the wait-state down-counter.
package memctl_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } memctl_state_e;

endpackage

// File: rtl/memory_access_controller_wait_counter.sv
// Loadable down-counter that times the memory wait states; zero_o flags
// the final wait cycle.
module wait_counter
  import memctl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/memory_access_controller.sv
// Single-word read/write sequencer for a wait-stated synchronous data memory.
// Optional MEMCTL_FAULT_EN adds an address range check against MEM_LIMIT.
module memory_access_controller
  import memctl_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] MEM_LIMIT   = {ADDR_W{1'b1}}
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Req,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RData,
  output logic              Fault,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemEn,
  output logic              MemWe,
  input  logic [DATA_W-1:0] MemRData
);

  memctl_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              fault_q, fault_d;
  logic              cnt_load, cnt_en, cnt_zero;
  logic              fault_hit;

`ifdef MEMCTL_FAULT_EN
  assign fault_hit = (Addr > MEM_LIMIT);
`else
  logic unused_mem_limit;
  assign fault_hit        = 1'b0;
  assign unused_mem_limit = ^MEM_LIMIT;
`endif

  wait_counter u_wait_counter (
    .clk_i      (CLK),
    .rst_ni     (Reset_n),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (CNT_W'(WAIT_STATES)),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    fault_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Req) begin
          if (fault_hit) begin
            // Out-of-range: skip the memory entirely and report at once
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            addr_d  = Addr;
            wdata_d = WData;
            we_d    = We;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = MemRData;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      fault_q <= fault_d;
    end
  end

  // Every output is a register or a decode of the state register alone
  assign Busy     = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
  assign Done     = (state_q == ST_DONE);
  assign MemEn    = (state_q == ST_ACCESS);
  assign MemWe    = (state_q == ST_ACCESS) && we_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign RData    = rdata_q;
  assign Fault    = fault_q;

endmodule
